// File: rtl/io_register_bank_if.sv
// CPU-side bus of the I/O register bank: address, write strobe and data in;
// read data and window hit out.
interface io_register_bank_if #(
    parameter int ADDR_BITS = 16,
    parameter int WIDTH     = 16
);
    logic [ADDR_BITS-1:0] address;
    logic                 load;
    logic [WIDTH-1:0]     in;
    logic [WIDTH-1:0]     out;
    logic                 hit;

    modport master (output address, load, in, input  out, hit);
    modport slave  (input  address, load, in, output out, hit);
endinterface

// File: rtl/io_register_bank.sv
// Memory-mapped I/O register bank: CHANNELS registers in a BASE-aligned window,
// each channel statically configured as RW, STROBE, CAPTURE or INPUT.
module io_register_bank #(
    parameter int                    WIDTH     = 16,
    parameter int                    CHANNELS  = 16,
    parameter int                    ADDR_BITS = 16,
    parameter logic [ADDR_BITS-1:0]  BASE      = ADDR_BITS'(16'h0F00),
    parameter logic [2*CHANNELS-1:0] MODES     = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    io_register_bank_if.slave         bus,
    input  logic [CHANNELS*WIDTH-1:0] ext_in,
    output logic [CHANNELS*WIDTH-1:0] ext_out
);
    localparam int IDX = $clog2(CHANNELS);
    localparam logic [ADDR_BITS:0] WIN_END = {1'b0, BASE} + (ADDR_BITS+1)'(CHANNELS);

    localparam logic [1:0] M_RW      = 2'b00;
    localparam logic [1:0] M_STROBE  = 2'b01;
    localparam logic [1:0] M_CAPTURE = 2'b10;

    logic [CHANNELS-1:0][WIDTH-1:0] ch_q, ch_d;
    logic [CHANNELS-1:0][WIDTH-1:0] sync1_q, sync2_q;
    logic [IDX-1:0]                 offset;
    logic                           hit_w;
    logic                           wr_en;
    logic                           wr_k;

    assign hit_w   = (bus.address >= BASE) && ({1'b0, bus.address} < WIN_END);
    assign offset  = bus.address[IDX-1:0] - BASE[IDX-1:0];
    assign wr_en   = bus.load && hit_w;
    assign bus.hit = hit_w;
    assign bus.out = hit_w ? ch_q[offset] : '0;
    assign ext_out = ch_q;

    // sync2_q doubles as the previous-value flop: a rise is seen as it enters
    // sync2, so the sticky bit lands on the same edge as sync2 and a set
    // always beats a same-cycle write-1-to-clear.
    always_comb begin
        ch_d = ch_q;
        wr_k = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            wr_k = wr_en && (offset == IDX'(k));
            case (MODES[2*k +: 2])
                M_RW:      if (wr_k) ch_d[k] = bus.in;
                M_STROBE:  ch_d[k] = wr_k ? bus.in : '0;
                M_CAPTURE: ch_d[k] = (ch_q[k] & ~(wr_k ? bus.in : '0))
                                   | (sync1_q[k] & ~sync2_q[k]);
                default:   ch_d[k] = sync1_q[k];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q    <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            ch_q    <= ch_d;
            sync1_q <= ext_in;
            sync2_q <= sync1_q;
        end
    end
endmodule

// File: tb/tb_io_register_bank.sv
// Scenario bench for io_register_bank: ch0 RW, ch1 STROBE, ch2 CAPTURE,
// ch3 INPUT, remaining channels RW.
module tb_io_register_bank;
    localparam int W  = 16;
    localparam int CH = 16;
    localparam int AB = 16;
    localparam logic [AB-1:0] BASE = 16'h0F00;
    localparam logic [2*CH-1:0] MODES = 32'h0000_00E4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [CH*W-1:0] ext_in = '0;
    logic [CH*W-1:0] ext_out;

    io_register_bank_if #(.ADDR_BITS(AB), .WIDTH(W)) bus ();

    io_register_bank #(
        .WIDTH(W), .CHANNELS(CH), .ADDR_BITS(AB), .BASE(BASE), .MODES(MODES)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .ext_in(ext_in), .ext_out(ext_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [CH*W-1:0] exp_q[$];
    logic [CH*W-1:0] obs, exp_v;
    logic [CH*W-1:0] e;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [AB-1:0] a, input logic ld, input logic [W-1:0] d);
        bus.address = a;
        bus.load    = ld;
        bus.in      = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(BASE, 1'b0, '0);
        step(); step();
        reset = 1'b0;
        #1;
        exp_q.push_back('0);
        exp_q.push_back('0);
        exp_q.push_back({{(CH*W-1){1'b0}}, 1'b1});
        obs = ext_out; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_ext_out got %h want %h", obs, exp_v); end
        obs = {{(CH*W-W){1'b0}}, bus.out}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_out got %h want %h", obs[W-1:0], exp_v[W-1:0]); end
        obs = {{(CH*W-1){1'b0}}, bus.hit}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_hit got %0d want %0d", obs[0], exp_v[0]); end
    endtask

    task automatic test_rw();
        drive(BASE, 1'b1, 16'hA5A5);
        exp_q.push_back({{(CH*W-W){1'b0}}, 16'hA5A5});
        step();
        drive(BASE + 4, 1'b1, 16'h5A5A);
        exp_q.push_back({{(CH*W-W){1'b0}}, 16'h5A5A});
        step();
        drive(BASE, 1'b0, '0);
        #1;
        obs = {{(CH*W-W){1'b0}}, bus.out}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v || bus.hit !== 1'b1) begin errors++; $display("FAIL rw_out_ch0 got %h hit %b want %h hit 1", obs[W-1:0], bus.hit, exp_v[W-1:0]); end
        checks++;
        if (ext_out[15:0] !== 16'hA5A5) begin errors++; $display("FAIL rw_ext_out_ch0 got %h want a5a5", ext_out[15:0]); end
        bus.address = BASE + 4;
        #1;
        obs = {{(CH*W-W){1'b0}}, bus.out}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rw_out_ch4 got %h want %h", obs[W-1:0], exp_v[W-1:0]); end
    endtask

    task automatic test_strobe();
        // single write: value for exactly one cycle
        drive(BASE + 1, 1'b1, 16'h0001);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0000);
        step();
        bus.load = 1'b0;
        #1;
        obs = ext_out[31:16]; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL strobe_single_hi got %h want %h", obs[W-1:0], exp_v[W-1:0]); end
        checks++;
        if (bus.out !== 16'h0001) begin errors++; $display("FAIL strobe_read got %h want 0001", bus.out); end
        step();
        obs = ext_out[31:16]; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL strobe_single_lo got %h want %h", obs[W-1:0], exp_v[W-1:0]); end
        // back-to-back writes: two cycles, no gap
        bus.load = 1'b1;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0000);
        step();
        obs = ext_out[31:16]; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL strobe_b2b_1 got %h want %h", obs[W-1:0], exp_v[W-1:0]); end
        step();
        bus.load = 1'b0;
        obs = ext_out[31:16]; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL strobe_b2b_2 got %h want %h", obs[W-1:0], exp_v[W-1:0]); end
        step();
        obs = ext_out[31:16]; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL strobe_b2b_end got %h want %h", obs[W-1:0], exp_v[W-1:0]); end
    endtask

    task automatic test_capture();
        drive(BASE + 2, 1'b0, '0);
        ext_in[32+3] = 1'b1;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0008);
        exp_q.push_back(16'h0008);
        step();  // first sampling edge
        obs = ext_out[47:32]; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL capture_early got %h want %h", obs[W-1:0], exp_v[W-1:0]); end
        step();
        obs = ext_out[47:32]; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL capture_set got %h want %h", obs[W-1:0], exp_v[W-1:0]); end
        step();
        obs = {{(CH*W-W){1'b0}}, bus.out}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL capture_sticky got %h want %h", obs[W-1:0], exp_v[W-1:0]); end
        // write-1-to-clear while input stays high
        drive(BASE + 2, 1'b1, 16'h0008);
        exp_q.push_back(16'h0000);
        step();
        bus.load = 1'b0;
        obs = ext_out[47:32]; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL capture_clear got %h want %h", obs[W-1:0], exp_v[W-1:0]); end
        // new edge coincident with a clear: set wins
        ext_in[32+3] = 1'b0;
        step(); step(); step();
        ext_in[32+3] = 1'b1;
        step();
        drive(BASE + 2, 1'b1, 16'h0008);
        exp_q.push_back(16'h0008);
        step();
        bus.load = 1'b0;
        obs = ext_out[47:32]; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL capture_set_wins got %h want %h", obs[W-1:0], exp_v[W-1:0]); end
    endtask

    task automatic test_input();
        ext_in[63:48] = 16'h1234;
        drive(BASE + 3, 1'b1, 16'hFFFF);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h1234);
        step();
        bus.load = 1'b0;
        obs = ext_out[63:48]; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL input_latency got %h want %h", obs[W-1:0], exp_v[W-1:0]); end
        step();
        obs = {{(CH*W-W){1'b0}}, bus.out}; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL input_value got %h want %h", obs[W-1:0], exp_v[W-1:0]); end
    endtask

    task automatic test_window();
        e = '0;
        e[15:0]  = 16'hA5A5;
        e[47:32] = 16'h0008;
        e[63:48] = 16'h1234;
        e[79:64] = 16'h5A5A;
        drive(BASE - 1, 1'b1, 16'hFFFF);
        #1;
        checks++;
        if (bus.hit !== 1'b0 || bus.out !== '0) begin errors++; $display("FAIL below_window got hit %b out %h want hit 0 out 0000", bus.hit, bus.out); end
        exp_q.push_back(e);
        step();
        bus.address = BASE + CH;
        #1;
        checks++;
        if (bus.hit !== 1'b0 || bus.out !== '0) begin errors++; $display("FAIL above_window got hit %b out %h want hit 0 out 0000", bus.hit, bus.out); end
        exp_q.push_back(e);
        step();
        bus.load = 1'b0;
        obs = ext_out; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL window_no_write got %h want %h", obs, exp_v); end
        bus.address = BASE + CH - 1;
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (bus.hit !== 1'b1 || bus.out !== exp_v[CH*W-1 -: W]) begin errors++; $display("FAIL last_in_window got hit %b out %h want hit 1 out %h", bus.hit, bus.out, exp_v[CH*W-1 -: W]); end
    endtask

    task automatic test_reset_mid();
        drive(BASE, 1'b1, 16'h7777);
        reset = 1'b1;
        exp_q.push_back('0);
        exp_q.push_back('0);
        e = '0;
        e[47:32] = 16'h0008;
        e[63:48] = 16'h1234;
        exp_q.push_back(e);
        step();
        reset = 1'b0;
        bus.load = 1'b0;
        #1;
        obs = ext_out; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v || bus.out !== '0) begin errors++; $display("FAIL reset_mid got %h out %h want %h out 0000", obs, bus.out, exp_v); end
        step();
        obs = ext_out; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_release_1 got %h want %h", obs, exp_v); end
        step();
        obs = ext_out; exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_release_2 got %h want %h", obs, exp_v); end
    endtask

    initial begin
        drive('0, 1'b0, '0);
        test_reset();
        test_rw();
        test_strobe();
        test_capture();
        test_input();
        test_window();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
